// File: rtl/envelope_line_capture.sv
// Purpose : decimate, rescale and saturate 48-bit envelope samples into fixed-length 16-bit scan lines.
// Latency : output sample pushed one edge after its final input; M_VALID two edges after that input.
// Backpr. : input side never stalls; a push into a full FIFO is dropped and OVERFLOW latches.
//
// Ports:
//   CLK, reset            sole clock (rising edge), synchronous active-high reset
//   DIN_VALID, DIN_X      envelope sample strobe and 48-bit two's-complement magnitude
//   LINE_START            single-cycle pulse arming capture of one line (honoured in IDLE only)
//   M_DATA/M_LAST/M_VALID output stream, transfers on M_VALID && M_READY
//   M_READY               downstream accept
//   OVERFLOW              sticky drop flag, cleared by the next accepted LINE_START
//   BUSY                  high while capturing or draining a line
module envelope_line_capture #(
  parameter int DECIM_LOG2 = 2,
  parameter int SHIFT      = 16,
  parameter int LINE_LEN   = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        DIN_VALID,
  input  logic [47:0] DIN_X,
  input  logic        LINE_START,
  output logic [15:0] M_DATA,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic        M_LAST,
  output logic        OVERFLOW,
  output logic        BUSY
);

  localparam int AW   = 48 + DECIM_LOG2;
  localparam int DC_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int LC_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [15:0]       pend_dat_q, pend_dat_d;
  logic              pend_last_q, pend_last_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_vld_q, out_vld_d;
  logic [15:0]       out_dat_q, out_dat_d;
  logic              out_last_q, out_last_d;
  logic [16:0]       mem_q [FIFO_DEPTH];

  logic [47:0]   x_clamp;
  logic [AW-1:0] sum;
  logic [AW-1:0] y;
  logic [15:0]   dec_out;
  logic          dec_done;
  logic          line_end;
  logic          take;
  logic          pop;
  logic          full;
  logic          fifo_wr;
  logic          drop;
  logic          load;
  logic          fifo_empty;

  // Datapath: clamp negatives, accumulate, average + rescale, saturate.
  always_comb begin
    x_clamp  = DIN_X[47] ? 48'd0 : DIN_X;
    sum      = acc_q + AW'(x_clamp);
    y        = sum >> (DECIM_LOG2 + SHIFT);
    dec_out  = (y > AW'(16'hFFFF)) ? 16'hFFFF : y[15:0];
    dec_done = (dcnt_q == DC_W'((1 << DECIM_LOG2) - 1));
    line_end = (lcnt_q == LC_W'(LINE_LEN - 1));
    take     = (state_q == ST_CAPTURE) && DIN_VALID;
  end

  // FIFO bookkeeping. The output register counts as one of the FIFO_DEPTH
  // entries, so occupancy is memory count plus the output-valid bit.
  always_comb begin
    pop        = out_vld_q && M_READY;
    full       = ((cnt_q + CW'(out_vld_q)) == CW'(FIFO_DEPTH));
    fifo_wr    = pend_vld_q && (!full || pop);
    drop       = pend_vld_q && full && !pop;
    // No bypass from the write port: an entry spends one cycle in memory
    // before reaching the output register.
    load       = (!out_vld_q || pop) && (cnt_q != '0);
    fifo_empty = (cnt_q == '0) && !out_vld_q;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;
    if (fifo_wr) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (load) begin
      rd_ptr_d   = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      out_vld_d  = 1'b1;
      out_dat_d  = mem_q[rd_ptr_q][16:1];
      out_last_d = mem_q[rd_ptr_q][0];
    end else if (pop) begin
      out_vld_d  = 1'b0;
    end
    cnt_d = cnt_q + CW'(fifo_wr) - CW'(load);
  end

  // Capture counters and the registered decimation result.
  always_comb begin
    acc_d       = acc_q;
    dcnt_d      = dcnt_q;
    lcnt_d      = lcnt_q;
    ovf_d       = ovf_q;
    pend_vld_d  = 1'b0;
    pend_dat_d  = pend_dat_q;
    pend_last_d = pend_last_q;
    if ((state_q == ST_IDLE) && LINE_START) begin
      acc_d  = '0;
      dcnt_d = '0;
      lcnt_d = '0;
      ovf_d  = 1'b0;
    end
    if (take) begin
      if (dec_done) begin
        acc_d       = '0;
        dcnt_d      = '0;
        // Line counter advances even if this push is later dropped, so the
        // line length stays fixed in input time.
        lcnt_d      = line_end ? '0 : lcnt_q + 1'b1;
        pend_vld_d  = 1'b1;
        pend_dat_d  = dec_out;
        pend_last_d = line_end;
      end else begin
        acc_d  = sum;
        dcnt_d = dcnt_q + 1'b1;
      end
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (LINE_START) state_d = ST_CAPTURE;
      ST_CAPTURE: if (take && dec_done && line_end) state_d = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty && !pend_vld_q) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM / stream outputs.
  always_comb begin
    BUSY     = (state_q != ST_IDLE);
    M_VALID  = out_vld_q;
    M_DATA   = out_dat_q;
    M_LAST   = out_last_q;
    OVERFLOW = ovf_q;
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_dat_q  <= '0;
      pend_last_q <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dcnt_q      <= dcnt_d;
      lcnt_q      <= lcnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_dat_q  <= pend_dat_d;
      pend_last_q <= pend_last_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      out_last_q  <= out_last_d;
    end
  end

  // FIFO storage; contents are don't-care once pointers are reset.
  always_ff @(posedge CLK) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= {pend_dat_q, pend_last_q};
    end
  end

endmodule

// File: tb/tb_envelope_line_capture.sv
module tb_envelope_line_capture;

  logic        CLK = 1'b0;
  logic        reset;
  logic        din_valid;
  logic [47:0] din_x;
  logic        line_start, line_start2;
  logic        m_ready, m_ready2;
  logic [15:0] m_data, m_data2;
  logic        m_valid, m_valid2, m_last, m_last2;
  logic        overflow, overflow2, busy, busy2;

  always #5 CLK = ~CLK;

  envelope_line_capture #(.DECIM_LOG2(2), .SHIFT(16), .LINE_LEN(4), .FIFO_DEPTH(16)) dut (
    .CLK(CLK), .reset(reset), .DIN_VALID(din_valid), .DIN_X(din_x), .LINE_START(line_start),
    .M_DATA(m_data), .M_VALID(m_valid), .M_READY(m_ready), .M_LAST(m_last),
    .OVERFLOW(overflow), .BUSY(busy));

  envelope_line_capture #(.DECIM_LOG2(2), .SHIFT(16), .LINE_LEN(20), .FIFO_DEPTH(16)) dut2 (
    .CLK(CLK), .reset(reset), .DIN_VALID(din_valid), .DIN_X(din_x), .LINE_START(line_start2),
    .M_DATA(m_data2), .M_VALID(m_valid2), .M_READY(m_ready2), .M_LAST(m_last2),
    .OVERFLOW(overflow2), .BUSY(busy2));

  int n_checks = 0;
  int n_pass   = 0;

  logic [16:0] sb1[$];
  logic [16:0] sb2[$];

  typedef struct packed {
    logic [47:0] x0, x1, x2, x3;
    logic [15:0] exp;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_sample(input logic [47:0] x);
    din_x     = x;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_group(input logic [47:0] x0, x1, x2, x3,
                            input logic [15:0] exp, input logic last);
    sb1.push_back({exp, last});
    drive_sample(x0);
    drive_sample(x1);
    drive_sample(x2);
    drive_sample(x3);
  endtask

  // LINE_START with a large same-cycle sample that must not be counted.
  task automatic start_line1();
    line_start = 1'b1;
    din_valid  = 1'b1;
    din_x      = 48'h0100_0000_0000;
    tick();
    line_start = 1'b0;
    din_valid  = 1'b0;
  endtask

  task automatic wait_idle1(input string name);
    int n = 0;
    while ((busy || sb1.size() != 0) && n < 500) begin
      tick();
      n++;
    end
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    check({name, "_sb_empty"}, 64'(sb1.size()), 64'd0);
  endtask

  // Scoreboard pops on each transfer.
  always @(negedge CLK) begin
    if (!reset && m_valid && m_ready) begin
      if (sb1.size() == 0) begin
        n_checks++;
        $display("FAIL dut1_extra_out: got %0h, expected no output", {m_data, m_last});
      end else check("dut1_out", 64'({m_data, m_last}), 64'(sb1.pop_front()));
    end
  end

  always @(negedge CLK) begin
    if (!reset && m_valid2 && m_ready2) begin
      if (sb2.size() == 0) begin
        n_checks++;
        $display("FAIL dut2_extra_out: got %0h, expected no output", {m_data2, m_last2});
      end else check("dut2_out", 64'({m_data2, m_last2}), 64'(sb2.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{48'd65536, 48'd65536, 48'd65536, 48'd65536, 16'd1};
    vt[1] = '{48'd65536, 48'd131072, 48'd196608, 48'd262144, 16'd2};
    vt[2] = '{48'h0100_0000_0000, 48'h0100_0000_0000, 48'h0100_0000_0000, 48'h0100_0000_0000, 16'hFFFF};
    vt[3] = '{48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFB, 48'hFFFF_FFFF_FFFB, 16'd0};
    vt[4] = '{48'hFF00_0000_0000, 48'hFF00_0000_0000, 48'd262144, 48'd262144, 16'd2};
    vt[5] = '{48'h3FFFF, 48'h3FFFF, 48'h3FFFF, 48'h3FFFF, 16'd3};
    vt[6] = '{48'h0000_FFFE_0000, 48'h0000_FFFE_0000, 48'h0000_FFFE_0000, 48'h0000_FFFE_0000, 16'hFFFE};
    vt[7] = '{48'h0001_0000_0000, 48'h0001_0000_0000, 48'h0001_0000_0000, 48'h0001_0000_0000, 16'hFFFF};

    reset = 1'b1; din_valid = 1'b0; din_x = '0;
    line_start = 1'b0; line_start2 = 1'b0; m_ready = 1'b1; m_ready2 = 1'b0;
    tick(); tick();
    check("rst_m_data",   64'(m_data),   64'd0);
    check("rst_m_valid",  64'(m_valid),  64'd0);
    check("rst_m_last",   64'(m_last),   64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_busy2",    64'(busy2),    64'd0);
    reset = 1'b0;
    tick();

    // Basic line with first-output latency.
    start_line1();
    check("busy_on_start", 64'(busy), 64'd1);
    for (int g = 0; g < 3; g++) send_group(48'd65536, 48'd65536, 48'd65536, 48'd65536, 16'd1, 1'b0);
    sb1.push_back({16'd1, 1'b1});
    for (int s = 0; s < 4; s++) drive_sample(48'd65536);
    check("lat_edge_k",  64'(m_valid), 64'd0);
    tick();
    check("lat_edge_k1", 64'(m_valid), 64'd0);
    tick();
    check("lat_edge_k2", 64'(m_valid), 64'd1);
    check("lat_last",    64'(m_last),  64'd1);
    wait_idle1("basic");

    // Table-driven lines: four vectors per line.
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) start_line1();
      send_group(vt[i].x0, vt[i].x1, vt[i].x2, vt[i].x3, vt[i].exp, (i % 4) == 3);
      if (i % 4 == 3) wait_idle1("table");
    end

    // Samples in IDLE are ignored; a second LINE_START mid-line is ignored.
    for (int s = 0; s < 5; s++) drive_sample(48'h0100_0000_0000);
    tick(); tick(); tick();
    check("idle_no_valid", 64'(m_valid), 64'd0);
    check("idle_no_busy",  64'(busy),    64'd0);
    start_line1();
    send_group(48'd65536, 48'd65536, 48'd65536, 48'd65536, 16'd1, 1'b0);
    sb1.push_back({16'd2, 1'b0});
    drive_sample(48'd131072);
    line_start = 1'b1;
    drive_sample(48'd131072);
    line_start = 1'b0;
    drive_sample(48'd131072);
    drive_sample(48'd131072);
    send_group(48'd65536, 48'd65536, 48'd65536, 48'd65536, 16'd1, 1'b0);
    send_group(48'd196608, 48'd196608, 48'd196608, 48'd196608, 16'd3, 1'b1);
    wait_idle1("ignore");

    // Reset mid-line with backpressure.
    m_ready = 1'b0;
    start_line1();
    for (int s = 0; s < 8; s++) drive_sample(48'd65536);
    drive_sample(48'h0100_0000_0000);
    drive_sample(48'h0100_0000_0000);
    tick(); tick();
    check("pre_rst_valid", 64'(m_valid), 64'd1);
    check("pre_rst_busy",  64'(busy),    64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb1.delete();
    check("post_rst_valid", 64'(m_valid), 64'd0);
    check("post_rst_busy",  64'(busy),    64'd0);
    m_ready = 1'b1;
    start_line1();
    for (int g = 0; g < 4; g++) send_group(48'd65536, 48'd65536, 48'd65536, 48'd65536, 16'd1, g == 3);
    wait_idle1("after_rst");

    // Overflow on the 20-sample-line instance with downstream stalled.
    line_start2 = 1'b1;
    tick();
    line_start2 = 1'b0;
    for (int g = 0; g < 16; g++) begin
      sb2.push_back({16'(g + 1), 1'b0});
      for (int s = 0; s < 4; s++) drive_sample(48'(g + 1) << 16);
    end
    tick(); tick(); tick();
    check("ovf_not_yet",  64'(overflow2), 64'd0);
    check("held_valid",   64'(m_valid2),  64'd1);
    check("held_data",    64'(m_data2),   64'd1);
    tick();
    check("held_stable",  64'({m_data2, m_last2}), 64'({16'd1, 1'b0}));
    for (int s = 0; s < 4; s++) drive_sample(48'd17 << 16);
    tick(); tick();
    check("ovf_set",      64'(overflow2), 64'd1);
    for (int g = 17; g < 20; g++)
      for (int s = 0; s < 4; s++) drive_sample(48'(g + 1) << 16);
    tick(); tick(); tick();
    check("drain_holds",  64'(busy2), 64'd1);
    m_ready2 = 1'b1;
    begin
      int n = 0;
      while ((busy2 || sb2.size() != 0) && n < 500) begin
        tick();
        n++;
      end
    end
    check("ovf_busy_low", 64'(busy2),      64'd0);
    check("ovf_sb_empty", 64'(sb2.size()), 64'd0);
    check("ovf_sticky",   64'(overflow2),  64'd1);
    line_start2 = 1'b1;
    tick();
    line_start2 = 1'b0;
    check("ovf_cleared",  64'(overflow2), 64'd0);
    check("busy2_start",  64'(busy2),     64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("busy2_reset",  64'(busy2),     64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/envelope_line_capture.md
# envelope_line_capture

Sink-side block for the envelope detector output stream. Consumes the detector's 48-bit magnitude samples (valid-qualified, no backpressure), applies power-of-two boxcar decimation, rescales and saturates to 16 bits, and frames the result into fixed-length scan lines. Lines are buffered in a small FIFO and delivered over a valid/ready stream toward the display/transfer path.

## Interface
Parameters:
- DECIM_LOG2, 2, decimation factor is 2^DECIM_LOG2 input samples per output sample (0..4)
- SHIFT, 16, extra right shift after averaging, before saturation
- LINE_LEN, 256, output samples per scan line (>=1)
- FIFO_DEPTH, 16, output FIFO entries, power of two

Ports:
- CLK  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- DIN_VALID  in  1  envelope sample strobe (detector DOUT_VALID)
- DIN_X  in  48  envelope sample, two's complement (detector DOUT_X)
- LINE_START  in  1  single-cycle pulse arming capture of one line
- M_DATA  out  16  output sample, unsigned
- M_VALID  out  1  M_DATA/M_LAST valid
- M_READY  in  1  downstream accept
- M_LAST  out  1  marks final sample of a line
- OVERFLOW  out  1  sticky: at least one sample dropped on FIFO full
- BUSY  out  1  high in CAPTURE or DRAIN

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: DIN_VALID ignored. LINE_START -> CAPTURE; clears accumulator, decimation counter, line counter, OVERFLOW.
- CAPTURE, per DIN_VALID: x = (DIN_X < 0) ? 0 : DIN_X; accumulator (48+DECIM_LOG2 bits, unsigned) += x; decimation counter++.
- On the 2^DECIM_LOG2-th sample: y = (acc + x) >> (DECIM_LOG2+SHIFT); out = (y > 16'hFFFF) ? 16'hFFFF : y[15:0]; push {out, last} where last = (line counter == LINE_LEN-1); accumulator and decimation counter clear; line counter++.
- After pushing the last sample of the line -> DRAIN. LINE_START in CAPTURE or DRAIN ignored.
- DRAIN: DIN_VALID ignored; -> IDLE when FIFO empty and no push pending.
- FIFO push with FIFO full and no pop in that cycle: sample dropped, OVERFLOW <= 1; line counter still advances (line length fixed in input time). Dropped last sample still causes CAPTURE -> DRAIN.
- Push and pop in same cycle when full: both succeed.
- Stream: entry transfers when M_VALID && M_READY. M_DATA/M_LAST stable while M_VALID && !M_READY.
- reset, any state: -> IDLE, FIFO flushed, all counters/accumulator cleared, in-flight line discarded.

## Timing
- Reset values: M_DATA=0, M_VALID=0, M_LAST=0, OVERFLOW=0, BUSY=0.
- LINE_START at edge n: BUSY=1 from edge n; a DIN_VALID in cycle n+1 is first counted sample (same-cycle DIN_VALID with LINE_START ignored).
- Decimation result registered: push at edge k+1 for final input sample at edge k.
- FIFO output registered: M_VALID earliest at edge k+2 (empty FIFO, M_READY=1). Throughput one sample/cycle at DECIM_LOG2=0.
- BUSY falls the edge after the FIFO empties in DRAIN.

## Test plan
- Basic line: LINE_LEN=4, DECIM_LOG2=2, SHIFT=16; LINE_START, 16 × DIN_X=65536 back-to-back, M_READY=1 -> 4 outputs of 1, M_LAST only on 4th, first M_VALID 2 cycles after 4th input, BUSY=0 after drain.
- Averaging/saturation: inputs 65536,131072,196608,262144 -> output 2 (640k>>18); inputs 2^40 ×4 -> 16'hFFFF.
- Negative clamp: DIN_X = -5 ×4 -> output 0; DIN_X mixes -2^40 and 262144 ×2 each -> output 2 (524288>>18 = 2).
- Backpressure/overflow: FIFO_DEPTH=16, LINE_LEN=20, M_READY=0 -> 16 entries held, OVERFLOW=1 at 17th push, line still ends (DRAIN); raise M_READY -> exactly 16 samples, none with M_LAST; next LINE_START clears OVERFLOW.
- Idle/ignore: DIN_VALID pulses in IDLE and a second LINE_START mid-CAPTURE -> no pushes from idle samples, line length unchanged.
- Reset mid-line: reset after 2 of 4 outputs pushed, M_READY=0 -> M_VALID=0, BUSY=0 next cycle; new LINE_START produces a clean 4-sample line starting with fresh accumulator.
